data_memory_ctrl: RTL and testbench
===================================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 10: cycles from request acceptance to ack_o; legal range 1..255.
REQ-002 SHALL have parameter DEPTH, default 512: number of 256-bit lines; power of two, at least 2.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i  input  1  request valid from data cache.
REQ-006 SHALL have port write_i  input  1  1 = line write, 0 = line read; qualified by enable_i.
REQ-007 SHALL have port addr_i  input  32  byte address; bits [4:0] ignored.
REQ-008 SHALL have port data_i  input  256  write line data.
REQ-009 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port data_o  output  256  read line data.
REQ-011 SHALL have port busy_o  output  1  high while a transaction is in flight.

Function
REQ-012 SHALL hold DEPTH x 256-bit storage; line index = addr_i[log2(DEPTH)+4:5]; higher address bits ignored, so indices wrap modulo DEPTH.
REQ-013 SHALL implement FSM states IDLE, BUSY, ACK.
REQ-014 SHALL, in IDLE with enable_i=1 at a rising edge, latch addr_i, data_i, write_i, load the latency counter and enter BUSY (or ACK directly when LATENCY=1).
REQ-015 SHALL, in BUSY, decrement the counter each cycle and ignore all request inputs, including enable_i deassertion; the latched transaction always completes.
REQ-016 SHALL assert ack_o for exactly the one cycle in ACK, beginning LATENCY rising edges after the acceptance edge.
REQ-017 SHALL commit a latched write into storage on the edge entering ACK.
REQ-018 SHALL, for a read, register the addressed line into data_o on the edge entering ACK.
REQ-019 SHALL hold data_o stable until the next read completes; writes SHALL NOT change data_o.
REQ-020 SHALL return to IDLE on the edge ending ACK regardless of enable_i; a request still presented then is accepted no earlier than the following edge, so each transaction is followed by at least one IDLE cycle.
REQ-021 SHALL accept a new request held continuously across that IDLE cycle, e.g. a write-back followed by a refill with enable_i held high and write_i lowered.
REQ-022 SHALL return the just-written data when a read follows a write to the same line.
REQ-023 SHALL drive busy_o=1 in BUSY and ACK, 0 in IDLE.

Reset
REQ-024 SHALL, on rst_i low, immediately force IDLE, ack_o=0, busy_o=0, data_o=0 and counter=0.
REQ-025 SHALL leave storage contents unaffected by reset; a write aborted by reset before its commit edge SHALL NOT modify storage.
REQ-026 SHALL accept requests from the first rising edge after rst_i deasserts.

Configuration
REQ-027 SHALL, with macro DMEM_STATS_EN defined, add outputs rd_cnt_o (16 bits) and wr_cnt_o (16 bits), each reset to 0.
REQ-028 SHALL, with DMEM_STATS_EN defined, increment rd_cnt_o or wr_cnt_o on each ack_o cycle according to the latched write_i, saturating at 16'hFFFF.
REQ-029 SHALL, without DMEM_STATS_EN, omit the rd_cnt_o and wr_cnt_o ports and counters entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover: LATENCY=10, write addr 0x0000_0040 data {8{32'hDEADBEEF}} -> ack_o high exactly 10 cycles after acceptance, for 1 cycle; busy_o high throughout.
REQ-031 SHALL cover: read 0x0000_0040 after REQ-030 -> data_o={8{32'hDEADBEEF}} in the ack cycle, stable afterwards.
REQ-032 SHALL cover: write to 0x0000_0060 with enable_i held, then write_i dropped to 0 and address changed to 0x0000_4060 (DEPTH=512) -> second transaction starts after exactly one IDLE cycle; its read returns the same line (index wrap).
REQ-033 SHALL cover: enable_i dropped at cycle 3 of BUSY -> ack_o still at cycle 10; address/data changes mid-BUSY have no effect.
REQ-034 SHALL cover: rst_i pulsed low at cycle 5 of a write to 0x0000_0080 -> ack_o never asserts, outputs 0 immediately; a later read of 0x0000_0080 returns the old contents.
REQ-035 SHALL cover: with DMEM_STATS_EN, 3 reads + 2 writes -> rd_cnt_o=3, wr_cnt_o=2; LATENCY=1 run -> ack_o one cycle after acceptance.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Fixed-latency 256-bit line memory behind a request/ack handshake for the data cache.
// Define DMEM_STATS_EN to add saturating read/write completion counters (rd_cnt_o, wr_cnt_o).
module data_memory_ctrl #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]  rd_cnt_o,
  output logic [15:0]  wr_cnt_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [255:0]       line_q;
  logic [255:0]       mem [DEPTH];

  logic               accept;
  logic               enter_ack;
  logic               cmt_wr;
  logic [IDX_W-1:0]   cmt_idx;
  logic [255:0]       cmt_line;
  logic [IDX_W-1:0]   req_idx;
  logic               addr_unused;

  assign req_idx     = addr_i[IDX_W+4:5];
  assign addr_unused = ^{addr_i[4:0], addr_i[31:IDX_W+5]};
  assign accept      = (state_q == IDLE) && enable_i;

  // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          if (LATENCY == 1) begin
            state_d = ACK;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is the acceptance edge, so the live inputs are used then.
  assign enter_ack = (state_d == ACK) && (state_q != ACK);
  assign cmt_wr    = accept ? write_i : wr_q;
  assign cmt_idx   = accept ? req_idx : idx_q;
  assign cmt_line  = accept ? data_i  : line_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q   <= write_i;
        idx_q  <= req_idx;
        line_q <= data_i;
      end
    end
  end

  // NOTE: storage is intentionally not reset; rst_i only gates the write so an aborted request never lands.
  always_ff @(posedge clk_i) begin
    if (rst_i && enter_ack && cmt_wr) mem[cmt_idx] <= cmt_line;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o <= '0;
    end else if (enter_ack && !cmt_wr) begin
      data_o <= mem[cmt_idx];
    end
  end

  assign ack_o  = (state_q == ACK);
  assign busy_o = (state_q != IDLE);

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else if (state_q == ACK) begin
      if (wr_q) begin
        if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
      end else begin
        if (rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: a per-cycle monitor compares ack/busy/data_o against a queue-driven model.
module tb_data_memory_ctrl;

  localparam int LAT  = 10;
  localparam int DEP  = 512;
  localparam int IDXW = 9;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         enable_i = 1'b0, write_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic [255:0] data_i = '0;
  logic         ack_o, busy_o;
  logic [255:0] data_o;

  logic         en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] din1 = '0;
  logic         ack1, busy1;
  logic [255:0] dout1;

`ifdef DMEM_STATS_EN
  logic [15:0]  rd_cnt_o, wr_cnt_o, rd_cnt1, wr_cnt1;
`endif

  data_memory_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o), .busy_o(busy_o)
`ifdef DMEM_STATS_EN
    , .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o)
`endif
  );

  data_memory_ctrl #(.LATENCY(1), .DEPTH(16)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(en1), .write_i(wr1),
    .addr_i(addr1), .data_i(din1), .ack_o(ack1), .data_o(dout1), .busy_o(busy1)
`ifdef DMEM_STATS_EN
    , .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           wr;
    int           idx;
    logic [255:0] data;
    int           acc;
  } txn_t;

  txn_t         q[$];
  logic [255:0] mem_m [int];
  logic [255:0] exp_dout = '0;
  int           cyc = 0;
  int           n_checks = 0, n_fail = 0;
  int           rd_n = 0, wr_n = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: the head transaction completes LAT cycles after its acceptance edge.
  always @(negedge clk_i) begin : mon
    bit exp_ack, exp_busy;
    exp_ack  = (q.size() > 0) && (cyc == q[0].acc + LAT - 1);
    exp_busy = (q.size() > 0) && (cyc >= q[0].acc);
    check("ack_o", {255'b0, ack_o}, {255'b0, exp_ack});
    check("busy_o", {255'b0, busy_o}, {255'b0, exp_busy});
    if (exp_ack) begin
      if (q[0].wr) begin
        mem_m[q[0].idx] = q[0].data;
        wr_n++;
      end else begin
        exp_dout = mem_m.exists(q[0].idx) ? mem_m[q[0].idx] : 'x;
        rd_n++;
      end
      void'(q.pop_front());
    end
    check("data_o", data_o, exp_dout);
  end

  // Called at negedge+1; gap is the number of edges until the DUT accepts it.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [255:0] d, input int gap);
    txn_t t;
    logic [IDXW-1:0] ix;
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = a;
    data_i   = d;
    ix       = a[IDXW+4:5];
    t.wr = wr; t.idx = int'(ix); t.data = d; t.acc = cyc + gap;
    q.push_back(t);
  endtask

  task automatic scramble();
    enable_i = 1'b0;
    write_i  = 1'($urandom);
    addr_i   = $urandom;
    data_i   = rnd256();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2 * LAT + 10; i++) begin
      @(negedge clk_i); #1;
      if (q.size() == 0) return;
    end
    check("timeout", {255'b0, 1'b1}, 256'b0);
    q.delete();
  endtask

  task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] d);
    issue(wr, a, d, 1);
    @(negedge clk_i); #1;
    scramble();
    wait_idle();
    @(negedge clk_i); #1;
  endtask

  task automatic pulse_reset();
    #1 rst_i = 1'b0;
    #1;
    check("rst_ack", {255'b0, ack_o}, 256'b0);
    check("rst_busy", {255'b0, busy_o}, 256'b0);
    check("rst_data", data_o, 256'b0);
    q.delete();
    exp_dout = '0;
    rd_n = 0;
    wr_n = 0;
    #1 rst_i = 1'b1;
  endtask

  initial begin
    logic [255:0] d_p, d_q, d_old, d_new, d1;
    logic [31:0]  a;
    d_p   = rnd256();
    d_q   = rnd256();
    d_old = rnd256();
    d_new = rnd256();
    d1    = rnd256();

    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b1;

    // Write then read of line 2; accepted on the first edge after reset release.
    txn(1'b1, 32'h0000_0040, {8{32'hDEADBEEF}});
    txn(1'b0, 32'h0000_0040, rnd256());

    // Write-back then refill with enable held: one IDLE cycle, index wrap at DEPTH=512.
    issue(1'b1, 32'h0000_0060, d_p, 1);
    wait_idle();
    issue(1'b0, 32'h0000_4060, rnd256(), 2);
    @(negedge clk_i); #1;
    @(negedge clk_i); #1;
    scramble();
    wait_idle();
    @(negedge clk_i); #1;

    // Request lines change in BUSY cycle 3; the latched write must still complete.
    issue(1'b1, 32'h0000_00A0, d_q, 1);
    repeat (3) @(negedge clk_i);
    #1 scramble();
    wait_idle();
    @(negedge clk_i); #1;
    txn(1'b0, 32'h0000_00A0, rnd256());

    // Reset during BUSY cycle 5 aborts the write; old contents survive.
    txn(1'b1, 32'h0000_0080, d_old);
    issue(1'b1, 32'h0000_0080, d_new, 1);
    @(negedge clk_i); #1;
    scramble();
    repeat (4) @(negedge clk_i);
    pulse_reset();
    repeat (2) @(negedge clk_i);
    #1;
    txn(1'b0, 32'h0000_0080, rnd256());

    for (int i = 0; i < 2; i++) begin
      a = {18'b0, 9'(16 + i * 7), 5'b0};
      txn(1'b1, a, rnd256());
      txn(1'b0, a, rnd256());
    end

`ifdef DMEM_STATS_EN
    check("rd_cnt", {240'b0, rd_cnt_o}, 256'(rd_n));
    check("wr_cnt", {240'b0, wr_cnt_o}, 256'(wr_n));
    check("rd_cnt_3", {240'b0, rd_cnt_o}, 256'd3);
    check("wr_cnt_2", {240'b0, wr_cnt_o}, 256'd2);
`endif

    // LATENCY=1 instance: ack in the cycle right after acceptance, wrap at DEPTH=16.
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0060; din1 = d1;
    @(negedge clk_i);
    check("l1_wr_ack", {255'b0, ack1}, {255'b0, 1'b1});
    check("l1_wr_busy", {255'b0, busy1}, {255'b0, 1'b1});
    #1 en1 = 1'b0;
    @(negedge clk_i);
    check("l1_idle_ack", {255'b0, ack1}, 256'b0);
    check("l1_idle_busy", {255'b0, busy1}, 256'b0);
    check("l1_wr_keep", dout1, 256'b0);
    #1 en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_0260; din1 = rnd256();
    @(negedge clk_i);
    check("l1_rd_ack", {255'b0, ack1}, {255'b0, 1'b1});
    check("l1_rd_data", dout1, d1);
    #1 en1 = 1'b0;
    @(negedge clk_i);
    check("l1_rd_hold", dout1, d1);
    check("l1_rd_done", {255'b0, ack1}, 256'b0);
`ifdef DMEM_STATS_EN
    check("l1_rd_cnt", {240'b0, rd_cnt1}, 256'd1);
    check("l1_wr_cnt", {240'b0, wr_cnt1}, 256'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit %0d reached", 100000);
    $fatal(1);
  end

endmodule
